// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package serial_adder_pkg;

  // Controller states: waiting, shifting bits, result-valid cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Legal range of the WIDTH parameter.
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Single-bit full adder used once per RUN cycle by serial_adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per clock, LSB first, WIDTH RUN cycles.
// Optional subtract mode is compiled in with SERIAL_ADDER_SUB_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             overflow
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_chk
    $error("serial_adder: WIDTH out of range");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, sum_msb;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             b_bit, fa_s, fa_co;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q, sub_d;
  // Subtraction inverts B one bit at a time as it leaves the shift register.
  assign b_bit = b_q[0] ^ sub_q;
`else
  assign b_bit = b_q[0];
`endif

  fa_cell u_fa (
    .a  (a_q[0]),
    .b  (b_bit),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Next-state and datapath: accept in IDLE/DONE, shift one bit per RUN edge.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_msb = '0;
    sum_msb[WIDTH-1] = fa_s;
`ifdef SERIAL_ADDER_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          a_d     = A;
          b_d     = B;
          cnt_d   = '0;
          sum_d   = '0;
`ifdef SERIAL_ADDER_SUB_EN
          sub_d   = sub;
          carry_d = sub ? 1'b1 : Cin;
`else
          carry_d = Cin;
`endif
        end
      end
      RUN: begin
        sum_d   = (sum_q >> 1) | sum_msb;
        carry_d = fa_co;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // carry_q here is the registered carry into the MSB.
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; synchronous reset wins over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign Sum      = sum_q;
  assign Cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH = 8).
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, cin, sub;
  logic [W-1:0] a, b;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .A        (a),
    .B        (b),
    .Cin      (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .Sum      (sum),
    .Cout     (cout),
    .overflow (ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, returns {overflow, cout, sum}.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic sb);
    logic [W-1:0] yy;
    logic         c, ov;
    logic [W:0]   full;
    yy   = sb ? ~y : y;
    c    = sb ? 1'b1 : ci;
    full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, c};
    ov   = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
    return {ov, full};
  endfunction

  // Wait (bounded) for done after an accept edge; checks busy while running.
  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (done === 1'b1) break;
      chk({tag, " busy_run"}, 64'(busy), 64'd1);
    end
    chk({tag, " latency"}, 64'(cyc), 64'(W));
    chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
  endtask

  task automatic chk_res(input string tag, input logic [W+1:0] e);
    chk({tag, " sum"},  64'(sum),  64'(e[W-1:0]));
    chk({tag, " cout"}, 64'(cout), 64'(e[W]));
    chk({tag, " ovf"},  64'(ovf),  64'(e[W+1]));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic ci, input logic sb);
    logic [W+1:0] e;
    e = ref_add(ai, bi, ci, sb);
    @(negedge clk);
    a = ai; b = bi; cin = ci; sub = sb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    chk({tag, " busy_accept"}, 64'(busy), 64'd1);
    chk({tag, " done_accept"}, 64'(done), 64'd0);
    wait_done(tag);
    chk_res(tag, e);
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, 64'(done), 64'd0);
    chk({tag, " busy_after"}, 64'(busy), 64'd0);
    chk_res({tag, " hold"}, e);
  endtask

  initial begin
    logic [W+1:0] e1, e2;
    logic         sb;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset sum",  64'(sum),  64'd0);
    chk("reset cout", 64'(cout), 64'd0);
    chk("reset ovf",  64'(ovf),  64'd0);
    rst = 1'b0;

    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    chk("add_ff_01 exact_sum", 64'(sum), 64'h00);
    run_op("ovf_7f_01", 8'h7F, 8'h01, 1'b1, 1'b0);
    chk("ovf_7f_01 exact_sum", 64'(sum), 64'h81);
    run_op("add_00_00", 8'h00, 8'h00, 1'b0, 1'b0);
    run_op("add_ff_ff", 8'hFF, 8'hFF, 1'b1, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1);
    chk("sub_05_07 exact_sum", 64'(sum), 64'hFE);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1);
    chk("sub_80_01 exact_sum", 64'(sum), 64'h7F);
`endif

    // Start held through RUN with changing operands; restart from DONE.
    e1 = ref_add(8'h3C, 8'h55, 1'b0, 1'b0);
    e2 = ref_add(8'h12, 8'h34, 1'b1, 1'b0);
    @(negedge clk);
    a = 8'h3C; b = 8'h55; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    begin
      int cyc;
      cyc = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        @(posedge clk); #1;
        cyc++;
        if (done === 1'b1) break;
      end
      chk("held latency", 64'(cyc), 64'(W));
    end
    chk_res("held first", e1);
    a = 8'h12; b = 8'h34; cin = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart busy", 64'(busy), 64'd1);
    chk("restart done", 64'(done), 64'd0);
    wait_done("restart");
    chk_res("restart", e2);

    // Leave Cout/overflow set, then reset on the 3rd RUN edge.
    run_op("add_80_80", 8'h80, 8'h80, 1'b0, 1'b0);
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b1; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort sum",  64'(sum),  64'd0);
    chk("abort cout", 64'(cout), 64'd0);
    chk("abort ovf",  64'(ovf),  64'd0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk); #1;
        if (done === 1'b1 || busy === 1'b1) seen++;
      end
      chk("abort quiet", 64'(seen), 64'd0);
    end

    // Randomized operations against the arithmetic reference.
    for (int i = 0; i < 40; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
      sb = 1'($urandom);
`else
      sb = 1'b0;
`endif
      run_op($sformatf("rand%0d", i), W'($urandom), W'($urandom), 1'($urandom), sb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
